// File: rtl/decode_stage_pipelined_if.sv
// Fetch/execute side bundle of the decode stage.
// The slave modport is the decode stage; the master modport is its environment.
interface decode_stage_pipelined_if #(
   parameter int ADDRESS_BITS = 32
);
   logic                    flush_i;
   logic                    in_valid_i;
   logic                    in_ready_o;
   logic [31:0]             instr_i;
   logic [ADDRESS_BITS-1:0] pc_i;
   logic [ADDRESS_BITS-1:0] pc_next_i;
   logic                    branch_hint_i;
   logic                    out_of_loop_i;
   logic                    out_valid_o;
   logic                    out_ready_i;
   logic [6:0]              op_o;
   logic [2:0]              funct3_o;
   logic [6:0]              funct7_o;
   logic [4:0]              rs1_o;
   logic [4:0]              rs2_o;
   logic [4:0]              rd_o;
   logic                    wen_o;
   logic [31:0]             imm32_o;
   logic [ADDRESS_BITS-1:0] pc_o;
   logic [ADDRESS_BITS-1:0] pc_next_o;
   logic                    redirect_o;
   logic [ADDRESS_BITS-1:0] target_pc_o;
   logic                    jalr_unres_o;
   logic                    enc_busy_o;
   logic                    enc_timeout_o;

   modport slave (
      input  flush_i, in_valid_i, instr_i, pc_i, pc_next_i,
      input  branch_hint_i, out_of_loop_i, out_ready_i,
      output in_ready_o, out_valid_o, op_o, funct3_o, funct7_o,
      output rs1_o, rs2_o, rd_o, wen_o, imm32_o, pc_o, pc_next_o,
      output redirect_o, target_pc_o, jalr_unres_o,
      output enc_busy_o, enc_timeout_o
   );

   modport master (
      output flush_i, in_valid_i, instr_i, pc_i, pc_next_i,
      output branch_hint_i, out_of_loop_i, out_ready_i,
      input  in_ready_o, out_valid_o, op_o, funct3_o, funct7_o,
      input  rs1_o, rs2_o, rd_o, wen_o, imm32_o, pc_o, pc_next_o,
      input  redirect_o, target_pc_o, jalr_unres_o,
      input  enc_busy_o, enc_timeout_o
   );
endinterface

// File: rtl/decode_stage_pipelined.sv
// RV32IM decode stage: field split, immediate extension, static prediction,
// one output register and an encryption-hold FSM with a watchdog.
module decode_stage_pipelined #(
   parameter int         ADDRESS_BITS = 32,
   parameter logic [6:0] ENC_OPCODE   = 7'b0001011,
   parameter int         ENC_TIMEOUT  = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   decode_stage_pipelined_if.slave bus
);
   localparam int AB = ADDRESS_BITS;
   localparam int CW = $clog2(ENC_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(ENC_TIMEOUT - 1);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic {
      RUN,
      ENC_HOLD
   } state_e;

   typedef struct packed {
      logic [6:0]    op;
      logic [2:0]    funct3;
      logic [6:0]    funct7;
      logic [4:0]    rs1;
      logic [4:0]    rs2;
      logic [4:0]    rd;
      logic          wen;
      logic [31:0]   imm;
      logic [AB-1:0] pc;
      logic [AB-1:0] pc_next;
      logic [AB-1:0] target;
      logic          jalr_unres;
   } dec_t;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;
   logic          valid_q, valid_d;
   logic          redirect_q, redirect_d;
   dec_t          dec_q, dec_d, dec_c;

   logic [31:0] ins;
   logic        is_load, is_opimm, is_store, is_branch;
   logic        is_jal, is_jalr, is_upper, is_enc;
   logic        is_shamt, is_itype, jalr_direct, taken;
   logic        in_ready, load;

   assign ins = bus.instr_i;

   assign is_load   = ins[6:0] == OP_LOAD;
   assign is_opimm  = ins[6:0] == OP_IMM;
   assign is_store  = ins[6:0] == OP_STORE;
   assign is_branch = ins[6:0] == OP_BRANCH;
   assign is_jal    = ins[6:0] == OP_JAL;
   assign is_jalr   = ins[6:0] == OP_JALR;
   assign is_upper  = ins[6:0] == OP_LUI || ins[6:0] == OP_AUIPC;
   assign is_enc    = ins[6:0] == ENC_OPCODE;

   assign is_shamt    = is_opimm && ins[13:12] == 2'b01;
   assign is_itype    = is_load || is_jalr || (is_opimm && !is_shamt);
   assign jalr_direct = is_jalr && ins[19:15] == 5'd0;
   assign taken       = is_jal || jalr_direct
                      || (is_branch && (ins[31] || bus.branch_hint_i));

   assign in_ready = state_q == RUN && (!valid_q || bus.out_ready_i);
   assign load     = bus.in_valid_i && in_ready && !bus.flush_i;

   // Combinational decode of the presented instruction
   always_comb begin
      dec_c         = '0;
      dec_c.op      = ins[6:0];
      dec_c.funct3  = ins[14:12];
      dec_c.funct7  = ins[31:25];
      dec_c.rs1     = ins[19:15];
      dec_c.rs2     = ins[24:20];
      dec_c.rd      = ins[11:7];
      dec_c.pc      = bus.pc_i;
      dec_c.pc_next = bus.pc_next_i;
      dec_c.wen     = !(is_store || is_branch || is_enc)
                    && ins[11:7] != 5'd0;
      dec_c.jalr_unres = is_jalr && !jalr_direct;
      unique case (1'b1)
         is_shamt:  dec_c.imm = {27'b0, ins[24:20]};
         is_itype:  dec_c.imm = {{20{ins[31]}}, ins[31:20]};
         is_store:  dec_c.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         is_branch: dec_c.imm = {{20{ins[31]}}, ins[7], ins[30:25],
                                 ins[11:8], 1'b0};
         is_jal:    dec_c.imm = {{12{ins[31]}}, ins[19:12], ins[20],
                                 ins[30:21], 1'b0};
         is_upper:  dec_c.imm = {ins[31:12], 12'b0};
         default:   dec_c.imm = '0;
      endcase
      unique case (1'b1)
         is_jal, is_branch: dec_c.target = bus.pc_i + dec_c.imm[AB-1:0];
         jalr_direct:       dec_c.target = {dec_c.imm[AB-1:1], 1'b0};
         default:           dec_c.target = '0;
      endcase
   end

   // Output register next state: capture on load, drain on consume
   always_comb begin
      dec_d      = dec_q;
      valid_d    = valid_q;
      redirect_d = 1'b0;
      if (bus.flush_i) begin
         valid_d = 1'b0;
      end else if (load) begin
         dec_d      = dec_c;
         valid_d    = 1'b1;
         redirect_d = taken;
      end else if (bus.out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Encryption hold FSM next state with watchdog
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (bus.flush_i) begin
         state_d   = RUN;
         cnt_d     = '0;
         timeout_d = 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (load && is_enc) begin
                  state_d = ENC_HOLD;
                  cnt_d   = '0;
               end
            end
            ENC_HOLD: begin
               if (bus.out_of_loop_i) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d   = RUN;
                  cnt_d     = '0;
                  timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // State and pipeline register update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         valid_q    <= 1'b0;
         redirect_q <= 1'b0;
         dec_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
         valid_q    <= valid_d;
         redirect_q <= redirect_d;
         dec_q      <= dec_d;
      end
   end

   assign bus.in_ready_o    = in_ready;
   assign bus.out_valid_o   = valid_q;
   assign bus.op_o          = dec_q.op;
   assign bus.funct3_o      = dec_q.funct3;
   assign bus.funct7_o      = dec_q.funct7;
   assign bus.rs1_o         = dec_q.rs1;
   assign bus.rs2_o         = dec_q.rs2;
   assign bus.rd_o          = dec_q.rd;
   assign bus.wen_o         = dec_q.wen;
   assign bus.imm32_o       = dec_q.imm;
   assign bus.pc_o          = dec_q.pc;
   assign bus.pc_next_o     = dec_q.pc_next;
   assign bus.target_pc_o   = dec_q.target;
   assign bus.jalr_unres_o  = dec_q.jalr_unres;
   assign bus.redirect_o    = redirect_q;
   assign bus.enc_busy_o    = state_q == ENC_HOLD;
   assign bus.enc_timeout_o = timeout_q;
endmodule
